// File: rtl/axi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_pkg: shared AXI read-channel constants and arbiter state encoding.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package axi_pkg;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [3:0] ID_ICACHE = 4'd0;
    localparam logic [3:0] ID_DCACHE = 4'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rd_arb_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rd_arb_pick: dcache-priority winner select with icache starvation guard.  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module rd_arb_pick #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             i_arvalid,
    input  logic             d_arvalid,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             pick_valid,
    output logic             pick_dcache
);

    localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(STARVE_MAX);

    always_comb begin
        pick_valid  = i_arvalid | d_arvalid;
        // dcache keeps priority until icache has watched STARVE_MAX dcache grants
        pick_dcache = d_arvalid & ~(i_arvalid & (starve_cnt == c_starve_max));
    end

endmodule
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_rd_arbiter: shares one AXI AR/R channel between icache and dcache.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    // icache
    input  logic              i_arvalid,
    input  logic [ADDR_W-1:0] i_araddr,
    input  logic [7:0]        i_arlen,
    output logic              i_arready,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rlast,
    input  logic              i_rready,
    // dcache
    input  logic              d_arvalid,
    input  logic [ADDR_W-1:0] d_araddr,
    input  logic [7:0]        d_arlen,
    output logic              d_arready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rlast,
    input  logic              d_rready,
    // master
    output logic              m_arvalid,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [3:0]        m_arid,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    input  logic              m_arready,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_rlast,
    output logic              m_rready,
    // status
    output logic              busy,
    output logic              len_err
);

    localparam int               CNT_W        = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(STARVE_MAX);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_grant_d;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic [7:0]        r_beat_cnt;
    logic              r_len_err;

    logic              w_pick_valid;
    logic              w_pick_d;
    logic              w_r_hs;

    rd_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_pick (
        .i_arvalid   (i_arvalid),
        .d_arvalid   (d_arvalid),
        .starve_cnt  (r_starve_cnt),
        .pick_valid  (w_pick_valid),
        .pick_dcache (w_pick_d)
    );

    assign w_r_hs    = (r_state == R) & m_rvalid & m_rready;
    assign busy      = (r_state != IDLE);
    assign len_err   = r_len_err;
    assign m_araddr  = r_addr;
    assign m_arlen   = r_len;
    assign m_arid    = r_grant_d ? ID_DCACHE : ID_ICACHE;
    assign m_arsize  = AXI_SIZE_4B;
    assign m_arburst = AXI_BURST_INCR;
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        i_arready   = 1'b0;
        d_arready   = 1'b0;
        i_rvalid    = 1'b0;
        d_rvalid    = 1'b0;
        i_rlast     = 1'b0;
        d_rlast     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = AR;
                end
            end
            AR: begin
                m_arvalid = 1'b1;
                if (r_grant_d) begin
                    d_arready = m_arready;
                end else begin
                    i_arready = m_arready;
                end
                if (m_arready) begin
                    w_state_nxt = R;
                end
            end
            R: begin
                if (r_grant_d) begin
                    m_rready = d_rready;
                    d_rvalid = m_rvalid;
                    d_rlast  = m_rlast;
                end else begin
                    m_rready = i_rready;
                    i_rvalid = m_rvalid;
                    i_rlast  = m_rlast;
                end
                if (w_r_hs && m_rlast) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_d    <= 1'b0;
            r_addr       <= '0;
            r_len        <= '0;
            r_starve_cnt <= '0;
            r_beat_cnt   <= '0;
            r_len_err    <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                if (w_pick_valid) begin
                    r_grant_d <= w_pick_d;
                    r_addr    <= w_pick_d ? d_araddr : i_araddr;
                    r_len     <= w_pick_d ? d_arlen  : i_arlen;
                end
                if (!i_arvalid || (w_pick_valid && !w_pick_d)) begin
                    r_starve_cnt <= '0;
                end else if (w_pick_d && (r_starve_cnt != c_starve_max)) begin
                    r_starve_cnt <= r_starve_cnt + CNT_W'(1);
                end
            end
            if ((r_state == AR) && m_arready) begin
                r_beat_cnt <= '0;
            end
            if (w_r_hs) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
                // rlast must coincide exactly with the beat numbered arlen
                if (m_rlast != (r_beat_cnt == r_len)) begin
                    r_len_err <= 1'b1;
                end
                if (m_rlast) begin
                    r_grant_d <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axi_rd_arbiter: directed self-checking bench for axi_rd_arbiter.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_arvalid, i_arready, i_rvalid, i_rlast, i_rready;
    logic [31:0] i_araddr, i_rdata;
    logic [7:0]  i_arlen;
    logic        d_arvalid, d_arready, d_rvalid, d_rlast, d_rready;
    logic [31:0] d_araddr, d_rdata;
    logic [7:0]  d_arlen;
    logic        m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
    logic [31:0] m_araddr, m_rdata;
    logic [7:0]  m_arlen;
    logic [3:0]  m_arid;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        busy, len_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi_rd_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_arvalid (i_arvalid),
        .i_araddr  (i_araddr),
        .i_arlen   (i_arlen),
        .i_arready (i_arready),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .i_rlast   (i_rlast),
        .i_rready  (i_rready),
        .d_arvalid (d_arvalid),
        .d_araddr  (d_araddr),
        .d_arlen   (d_arlen),
        .d_arready (d_arready),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_rlast   (d_rlast),
        .d_rready  (d_rready),
        .m_arvalid (m_arvalid),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arid    (m_arid),
        .m_arsize  (m_arsize),
        .m_arburst (m_arburst),
        .m_arready (m_arready),
        .m_rvalid  (m_rvalid),
        .m_rdata   (m_rdata),
        .m_rlast   (m_rlast),
        .m_rready  (m_rready),
        .busy      (busy),
        .len_err   (len_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expects the arbiter to be in AR at the next falling edge.
    task automatic do_ar(input bit is_d, input logic [31:0] addr, input logic [7:0] len,
                         input int wait_cyc, input bit drop);
        for (int w = 0; w < wait_cyc; w++) begin
            @(negedge clk);
            m_arready = 1'b0;
            m_rvalid  = 1'b1;
            #1;
            chk("ar_wait_valid", m_arvalid, 1);
            chk("ar_wait_ready", is_d ? d_arready : i_arready, 0);
            chk("ar_rvalid_ignored", {m_rready, i_rvalid, d_rvalid}, 0);
        end
        @(negedge clk);
        m_rvalid  = 1'b0;
        m_arready = 1'b1;
        #1;
        chk("ar_valid", m_arvalid, 1);
        chk("ar_id", m_arid, is_d ? 4'd1 : 4'd0);
        chk("ar_addr", m_araddr, addr);
        chk("ar_len", m_arlen, len);
        chk("ar_size_burst", {m_arsize, m_arburst}, {3'b010, 2'b01});
        chk("ar_ready_granted", is_d ? d_arready : i_arready, 1);
        chk("ar_ready_other", is_d ? i_arready : d_arready, 0);
        chk("ar_busy", busy, 1);
        @(posedge clk);
        #1;
        m_arready = 1'b0;
        if (drop) begin
            if (is_d) d_arvalid = 1'b0;
            else      i_arvalid = 1'b0;
        end
    endtask

    task automatic beat(input bit is_d, input logic [31:0] data, input bit last, input bit rdy);
        @(negedge clk);
        m_rvalid = 1'b1;
        m_rdata  = data;
        m_rlast  = last;
        i_rready = !is_d && rdy;
        d_rready = is_d && rdy;
        #1;
        chk("r_valid", is_d ? d_rvalid : i_rvalid, 1);
        chk("r_valid_other", is_d ? i_rvalid : d_rvalid, 0);
        chk("r_data", is_d ? d_rdata : i_rdata, data);
        chk("r_data_bcast", is_d ? i_rdata : d_rdata, data);
        chk("r_last", is_d ? d_rlast : i_rlast, last);
        chk("m_rready", m_rready, rdy);
    endtask

    task automatic do_burst(input bit is_d, input int nbeats, input int rlast_at, input logic [31:0] base);
        for (int k = 0; k < nbeats; k++) begin
            beat(is_d, 32'(base + k), (k == rlast_at), 1'b1);
        end
        @(negedge clk);
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        i_rready = 1'b0;
        d_rready = 1'b0;
        #1;
        chk("idle_after_last", busy, 0);
        chk("idle_m_rready", m_rready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_arvalid = 0; i_araddr = 0; i_arlen = 0; i_rready = 0;
        d_arvalid = 0; d_araddr = 0; d_arlen = 0; d_rready = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rlast = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valids", {m_arvalid, m_rready, i_arready, d_arready, i_rvalid, d_rvalid}, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_addr_len", {m_araddr, m_arlen}, 0);
        @(negedge clk);
        rst = 1'b0;

        // icache alone, master accepts after 2 cycles
        @(negedge clk);
        i_arvalid = 1; i_araddr = 32'h1C00_0040; i_arlen = 8'd3;
        #1;
        chk("req_busy_low", busy, 0);
        do_ar(0, 32'h1C00_0040, 8'd3, 2, 1);
        do_burst(0, 4, 3, 32'hA000_0000);
        chk("ic_len_ok", len_err, 0);

        // simultaneous requests: dcache first, icache right after
        d_arvalid = 1; d_araddr = 32'h8000_1000; d_arlen = 8'd1;
        i_arvalid = 1; i_araddr = 32'h1C00_0080; i_arlen = 8'd1;
        do_ar(1, 32'h8000_1000, 8'd1, 0, 1);
        do_burst(1, 2, 1, 32'hB000_0000);
        do_ar(0, 32'h1C00_0080, 8'd1, 0, 1);
        do_burst(0, 2, 1, 32'hC000_0000);

        // starvation: two rounds of 4 dcache grants then one icache grant
        i_arvalid = 1; i_araddr = 32'h1C00_0100; i_arlen = 8'd0;
        d_arvalid = 1; d_arlen = 8'd0;
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int g = 0; g < 4; g++) begin
                d_araddr = 32'h8000_0000 + 32'(g * 64);
                do_ar(1, 32'h8000_0000 + 32'(g * 64), 8'd0, 0, 0);
                do_burst(1, 1, 0, 32'hD000_0000 + 32'(g));
            end
            do_ar(0, 32'h1C00_0100, 8'd0, 0, 0);
            do_burst(0, 1, 0, 32'hE000_0000);
        end
        i_arvalid = 0; d_arvalid = 0;

        // early rlast on beat 2 of arlen=3
        @(negedge clk);
        i_arvalid = 1; i_araddr = 32'h1C00_0200; i_arlen = 8'd3;
        do_ar(0, 32'h1C00_0200, 8'd3, 0, 1);
        do_burst(0, 2, 1, 32'h1111_0000);
        chk("early_last_err", len_err, 1);
        @(negedge clk);
        i_arvalid = 1; i_araddr = 32'h1C00_0240; i_arlen = 8'd1;
        do_ar(0, 32'h1C00_0240, 8'd1, 0, 1);
        do_burst(0, 2, 1, 32'h2222_0000);
        chk("len_err_sticky", len_err, 1);

        // async reset mid-R
        @(negedge clk);
        i_arvalid = 1; i_araddr = 32'h1C00_0300; i_arlen = 8'd3;
        do_ar(0, 32'h1C00_0300, 8'd3, 0, 1);
        beat(0, 32'h3333_0000, 0, 1);
        @(negedge clk);
        m_rvalid = 1; m_rdata = 32'h3333_0001; i_rready = 1;
        #1;
        rst = 1'b1;
        #1;
        chk("amid_busy", busy, 0);
        chk("amid_valids", {m_arvalid, m_rready, i_arready, d_arready, i_rvalid, d_rvalid}, 0);
        chk("amid_len_err", len_err, 0);
        chk("amid_addr", {m_araddr, m_arlen, m_arid}, 0);
        m_rvalid = 0; i_rready = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        i_arvalid = 1; i_araddr = 32'h1C00_0340; i_arlen = 8'd3;
        do_ar(0, 32'h1C00_0340, 8'd3, 1, 1);
        do_burst(0, 4, 3, 32'h4444_0000);
        chk("post_rst_len_ok", len_err, 0);

        // i_rready low for 3 cycles mid-burst
        @(negedge clk);
        i_arvalid = 1; i_araddr = 32'h1C00_0400; i_arlen = 8'd3;
        do_ar(0, 32'h1C00_0400, 8'd3, 0, 1);
        beat(0, 32'h5555_0000, 0, 1);
        repeat (3) beat(0, 32'h5555_0001, 0, 0);
        beat(0, 32'h5555_0001, 0, 1);
        beat(0, 32'h5555_0002, 0, 1);
        do_burst(0, 1, 0, 32'h5555_0003);
        chk("stall_len_ok", len_err, 0);

        // burst runs past arlen=0 without rlast
        @(negedge clk);
        d_arvalid = 1; d_araddr = 32'h8000_2000; d_arlen = 8'd0;
        do_ar(1, 32'h8000_2000, 8'd0, 0, 1);
        beat(1, 32'h6666_0000, 0, 1);
        do_burst(1, 1, 0, 32'h6666_0001);
        chk("missing_last_err", len_err, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
